mips_mult_div: RTL

//   Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core.

---
 rtl/mips_mult_div_if.sv | 38 +++
 rtl/mips_mult_div.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mips_mult_div_if.sv
// Operand, HI/LO-write and result bundle between the MIPS core and mips_mult_div.
// The div_zero flag exists only when MULDIV_DIV0_EN is defined.
interface mips_mult_div_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             signal_write_hi;
    logic             signal_write_lo;
    logic [WIDTH-1:0] write_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
`ifdef MULDIV_DIV0_EN
    logic             div_zero;

    modport master (
        output start, op, rs_data, rt_data, signal_write_hi, signal_write_lo, write_data,
        input  busy, done, hi, lo, div_zero
    );
    modport slave (
        input  start, op, rs_data, rt_data, signal_write_hi, signal_write_lo, write_data,
        output busy, done, hi, lo, div_zero
    );
`else
    modport master (
        output start, op, rs_data, rt_data, signal_write_hi, signal_write_lo, write_data,
        input  busy, done, hi, lo
    );
    modport slave (
        input  start, op, rs_data, rt_data, signal_write_hi, signal_write_lo, write_data,
        output busy, done, hi, lo
    );
`endif
endinterface

// File: rtl/mips_mult_div.sv
// Iterative 34-cycle MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// Define MULDIV_DIV0_EN to add the sticky div_zero result flag.
module mips_mult_div #(
    parameter int unsigned WIDTH = 32
) (
    input logic            clk,
    input logic            rst_n,
    mips_mult_div_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    state_e             state_q;
    logic               is_div_q;
    logic               neg_a_q;
    logic               neg_b_q;
    logic               div0_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [5:0]         cnt_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;
`ifdef MULDIV_DIV0_EN
    logic               div_zero_q;
`endif

    logic               neg_a_d;
    logic               neg_b_d;
    logic [WIDTH-1:0]   abs_a_d;
    logic [WIDTH-1:0]   abs_b_d;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   rem_diff;
    logic [WIDTH-1:0]   rem_nxt;
    logic               q_bit;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        neg_a_d  = ~bus.op[0] & bus.rs_data[WIDTH-1];
        neg_b_d  = ~bus.op[0] & bus.rt_data[WIDTH-1];
        abs_a_d  = neg_a_d ? -bus.rs_data : bus.rs_data;
        abs_b_d  = neg_b_d ? -bus.rt_data : bus.rt_data;

        // Multiply: add multiplicand into the upper half, then shift the whole accumulator right.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
        // Divide: upper half is the partial remainder, lower half collects quotient bits.
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
        q_bit    = (rem_sh >= {1'b0, b_q});
        rem_diff = rem_sh[WIDTH-1:0] - b_q;
        rem_nxt  = q_bit ? rem_diff : rem_sh[WIDTH-1:0];
        acc_d    = is_div_q ? {rem_nxt, acc_q[WIDTH-2:0], q_bit}
                            : {mul_sum, acc_q[WIDTH-1:1]};

        prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        quo_fix  = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        // With a zero divisor the remainder ends up as |rs|, so this restores the raw dividend.
        rem_fix  = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            is_div_q   <= 1'b0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            div0_q     <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef MULDIV_DIV0_EN
            div_zero_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q  <= CALC;
                        busy_q   <= 1'b1;
                        is_div_q <= bus.op[1];
                        neg_a_q  <= neg_a_d;
                        neg_b_q  <= neg_b_d;
                        div0_q   <= (bus.rt_data == '0);
                        a_q      <= abs_a_d;
                        b_q      <= abs_b_d;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                    end else begin
                        if (bus.signal_write_hi) hi_q <= bus.write_data;
                        if (bus.signal_write_lo) lo_q <= bus.write_data;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (is_div_q) a_q <= {a_q[WIDTH-2:0], 1'b0};
                    else          b_q <= {1'b0, b_q[WIDTH-1:1]};
                    if (cnt_q == 6'd31) state_q <= FIX;
                end
                FIX: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                    if (is_div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= div0_q ? '1 : quo_fix;
                    end else begin
                        {hi_q, lo_q} <= prod_fix;
                    end
`ifdef MULDIV_DIV0_EN
                    div_zero_q <= is_div_q & div0_q;
`endif
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
`ifdef MULDIV_DIV0_EN
    assign bus.div_zero = div_zero_q;
`endif
endmodule
